// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that owns a small register file and
// drives an external ADD/SUB/AND/OR ALU to retire one command at a time.
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op/rd/ra/rb   opcode and register addresses; cmd_imm is the LDI value
//   alu_a/b/ctrl      operands and ALUControl toward the ALU
//   alu_result/z/n/c/v  ALU result and flags back from the ALU
//   done              one-cycle pulse when a command retires
//   flags             latched {Z,N,C,V}
//   dbg_addr/dbg_data combinational register-file read port
module alu_sequencer #(
   parameter  int unsigned WIDTH  = 8,
   parameter  int unsigned NREG   = 4,
   localparam int unsigned ADDR_W = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_ra,
   input  logic [ADDR_W-1:0] cmd_rb,
   input  logic [WIDTH-1:0]  cmd_imm,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [1:0]        alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_c,
   input  logic              alu_v,
   output logic              done,
   output logic [3:0]        flags,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [WIDTH-1:0]  dbg_data
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [2:0]  OP_LDI = 3'b100;
   localparam logic [2:0]  OP_MUL = 3'b101;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [ADDR_W-1:0]  rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
   logic [WIDTH-1:0]   imm_q, imm_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic [WIDTH-1:0]   acc_q, acc_d, res_q, res_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         flags_q, flags_d;
   logic               nop_done_q, nop_done_d;
   logic [WIDTH-1:0]   rf_q [NREG];
   logic [WIDTH-1:0]   rf_d [NREG];
   logic               accept_c;
   logic               mul_last_c;

   assign accept_c   = cmd_valid && (state_q == S_IDLE);
   assign mul_last_c = (cnt_q == CNT_W'(WIDTH - 1));
   assign flags      = flags_q;
   assign dbg_data   = rf_q[dbg_addr];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept_c) begin
            if (cmd_op == OP_LDI)          state_d = S_WB;
            else if (cmd_op[2:1] == 2'b11) state_d = S_IDLE;
            else                           state_d = S_READ;
         end
         S_READ:  state_d = (op_q == OP_MUL) ? S_MUL : S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_MUL:   if (mul_last_c) state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs; a NOP retires from IDLE through a one-cycle flag
   always_comb begin
      cmd_ready = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = 2'b00;
      done      = nop_done_q;
      case (state_q)
         S_IDLE: cmd_ready = 1'b1;
         S_EXEC: begin
            alu_a    = opa_q;
            alu_b    = opb_q;
            alu_ctrl = op_q[1:0];
         end
         S_MUL: begin
            alu_a = acc_q;
            alu_b = opb_q[0] ? opa_q : '0;
         end
         S_WB:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: capture, operand read, execute, shift-add, writeback
   always_comb begin
      op_d       = op_q;
      rd_d       = rd_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      imm_d      = imm_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      res_d      = res_q;
      flags_d    = flags_q;
      nop_done_d = 1'b0;
      rf_d       = rf_q;
      case (state_q)
         S_IDLE: if (accept_c) begin
            op_d       = cmd_op;
            rd_d       = cmd_rd;
            ra_d       = cmd_ra;
            rb_d       = cmd_rb;
            imm_d      = cmd_imm;
            nop_done_d = (cmd_op[2:1] == 2'b11);
         end
         S_READ: begin
            opa_d = rf_q[ra_q];
            opb_d = rf_q[rb_q];
            acc_d = '0;
            cnt_d = '0;
         end
         S_EXEC: begin
            res_d   = alu_result;
            flags_d = {alu_z, alu_n, alu_c, alu_v};
         end
         S_MUL: begin
            acc_d = alu_result;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
            cnt_d = cnt_q + 1'b1;
            // Final partial sum is the product; carry/overflow are meaningless here
            if (mul_last_c) begin
               res_d   = alu_result;
               flags_d = {alu_result == '0, alu_result[WIDTH-1], 2'b00};
            end
         end
         S_WB: rf_d[rd_q] = (op_q == OP_LDI) ? imm_q : res_q;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= '0;
         rd_q       <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         imm_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         res_q      <= '0;
         flags_q    <= '0;
         nop_done_q <= 1'b0;
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      end else begin
         op_q       <= op_d;
         rd_q       <= rd_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         imm_q      <= imm_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         res_q      <= res_d;
         flags_q    <= flags_d;
         nop_done_q <= nop_done_d;
         rf_q       <= rf_d;
      end
   end

endmodule
